pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard/stall controller for the 5-stage RV32I core. Replaces the
//  combinational-only detector. Adds selectable forwarding mode, multi-cycle EX-op stall FSM,
//  data-memory wait freeze with timeout, and saturating stall/flush counters.
//  Sits beside the pipeline registers and drives their enable/flush inputs.
// PARAMETERS
//  FWD_EN       0   0: stall on any RAW vs EX/MEM(/WB); 1: forwarding present, stall only on EX load-use
//  RF_BYPASS    0   1: regfile write-before-read, WB excluded from RAW check (FWD_EN=0 only)
//  MEM_TIMEOUT  64  max MEM_WAIT cycles before forced release (>=2)
//  CNT_W        16  perf counter width
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      reset, async, active-high
//  id_rs1_addr_i   in   5      ID source reg 1
//  id_rs2_addr_i   in   5      ID source reg 2
//  id_uses_rs1_i   in   1      ID instr reads rs1
//  id_uses_rs2_i   in   1      ID instr reads rs2
//  ex_rd_addr_i/ex_rd_wren_i, mem_rd_addr_i/mem_rd_wren_i, wb_rd_addr_i/wb_rd_wren_i  in 5/1  producers
//  ex_is_load_i    in   1      EX instr is a load
//  ex_redirect_i   in   1      branch/jump taken, resolved in EX
//  ex_mc_start_i   in   1      EX holds multi-cycle op (MUL/DIV), level
//  ex_mc_done_i    in   1      multi-cycle result valid this cycle
//  mem_req_i       in   1      MEM stage memory access active
//  mem_ack_i       in   1      memory access completes this cycle
//  pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o   out 1   stage register enables
//  id_flush_o, ex_flush_o, mem_flush_o            out 1   sync clear (bubble) of ID/EX/MEM regs
//  state_o         out  2      FSM state (hz_state_e)
//  mem_timeout_o   out  1      sticky timeout error
//  stall_cnt_o     out  CNT_W  cycles with pc_en_o=0
//  flush_cnt_o     out  CNT_W  accepted redirects
// BEHAVIOUR
//  Reset: state=RUN, counters=0, mem_timeout_o=0, wait counter=0; outputs then follow RUN decode.
//  Default (RUN, no event): all en=1, all flush=0.
//  RAW match = wren && rd!=0 && ((rd==rs1 && uses_rs1)||(rd==rs2 && uses_rs2)).
//   FWD_EN=0: stall if match on EX or MEM, or WB when RF_BYPASS=0. FWD_EN=1: only EX match && ex_is_load_i.
//  Priority per cycle, highest first:
//   1 MEM_WAIT/mem_req_i&&!mem_ack_i: all en=0, flushes=0 (full freeze); RUN->MEM_WAIT.
//   2 MC: RUN && ex_mc_start_i && !ex_mc_done_i -> pc/id/ex en=0, mem_flush=1; ->MC_BUSY.
//     MC_BUSY: same outputs until ex_mc_done_i; done cycle: all en=1, ->RUN. Start&&done in RUN: no stall.
//   3 ex_redirect_i: id_flush=1, ex_flush=1, pc_en=1; flush_cnt+1. Overrides RAW (wrong-path ID).
//   4 RAW: pc_en=0, id_en=0, ex_flush=1 (bubble).
//  MEM_WAIT: wait counter +1 per cycle; mem_ack_i -> all en=1, ->RUN, counter=0.
//   Counter==MEM_TIMEOUT-1 without ack: mem_timeout_o<=1 (sticky), mem_flush=1, en=1, ->RUN.
//   Entry from MC_BUSY returns to MC_BUSY (saved return state), not RUN.
//  Redirect during freeze is held (EX frozen), acted on first unfrozen cycle; counted once.
//  Counters saturate at all-ones; stall_cnt counts freeze, MC and RAW cycles.
//  Reset mid-operation: async to RUN; any in-flight MC/MEM wait is abandoned.
//  All hazard outputs combinational from state+inputs; no added latency.
// STRUCTURE
//  hazard_pkg: hz_state_e {RUN, MC_BUSY, MEM_WAIT}, REG_ADDR_W=5, stage enum for debug.
//  Sub-module hazard_raw_cmp (one producer vs rs1/rs2 match), instantiated x3.
//  Top: FSM + wait counter + priority decode + perf counters.
// TESTING
//  FWD_EN=0: EX add x5, ID add x6,x5,x1 -> 2 stall cycles (EX,MEM), 3 if RF_BYPASS=0; stall_cnt=3.
//  FWD_EN=1: EX lw x5, ID uses x5 -> 1 stall, ex_flush=1; EX add x5 -> no stall.
//  ex_redirect_i with concurrent RAW -> id_flush=ex_flush=1, pc_en=1, flush_cnt=1, no stall.
//  ex_mc_start_i 1, done after 8 cycles -> pc/id/ex en=0 for 8 cycles, mem_flush=1, back to RUN.
//  mem_req_i=1, ack never, MEM_TIMEOUT=64 -> freeze 63 cycles, then mem_timeout_o=1, mem_flush pulse.
//  rst_i asserted mid MC_BUSY -> state_o=RUN, counters=0 immediately (async).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // Pipeline stage tags, used only for debug visibility.
    typedef enum logic [2:0] {
        STG_IF  = 3'd0,
        STG_ID  = 3'd1,
        STG_EX  = 3'd2,
        STG_MEM = 3'd3,
        STG_WB  = 3'd4
    } hz_stage_e;

endpackage

// File: rtl/hazard_raw_cmp.sv
// RAW match of one producer stage against the ID-stage source registers.
module hazard_raw_cmp
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rd_wren,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    output logic                  match
);

    // x0 is hardwired zero, so writes to it never create a dependency.
    assign match = rd_wren && (rd_addr != '0) &&
                   (((rd_addr == rs1_addr) && uses_rs1) ||
                    ((rd_addr == rs2_addr) && uses_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: RAW detection, multi-cycle EX stall,
// data-memory wait freeze with timeout, and saturating perf counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_EN      = 0,
    parameter int unsigned RF_BYPASS   = 0,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_rd_wren_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic                  mem_rd_wren_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic                  wb_rd_wren_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_redirect_i,
    input  logic                  ex_mc_start_i,
    input  logic                  ex_mc_done_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_en_o,
    output logic                  id_en_o,
    output logic                  ex_en_o,
    output logic                  mem_en_o,
    output logic                  wb_en_o,
    output logic                  id_flush_o,
    output logic                  ex_flush_o,
    output logic                  mem_flush_o,
    output logic [1:0]            state_o,
    output logic                  mem_timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e          state_q, state_d, ret_q, ret_d, eff_state;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               ex_match, mem_match, wb_match, raw_hazard;
    logic               wait_expired, redirect_taken;

    hazard_raw_cmp u_cmp_ex (
        .rd_addr(ex_rd_addr_i), .rd_wren(ex_rd_wren_i),
        .rs1_addr(id_rs1_addr_i), .rs2_addr(id_rs2_addr_i),
        .uses_rs1(id_uses_rs1_i), .uses_rs2(id_uses_rs2_i), .match(ex_match)
    );
    hazard_raw_cmp u_cmp_mem (
        .rd_addr(mem_rd_addr_i), .rd_wren(mem_rd_wren_i),
        .rs1_addr(id_rs1_addr_i), .rs2_addr(id_rs2_addr_i),
        .uses_rs1(id_uses_rs1_i), .uses_rs2(id_uses_rs2_i), .match(mem_match)
    );
    hazard_raw_cmp u_cmp_wb (
        .rd_addr(wb_rd_addr_i), .rd_wren(wb_rd_wren_i),
        .rs1_addr(id_rs1_addr_i), .rs2_addr(id_rs2_addr_i),
        .uses_rs1(id_uses_rs1_i), .uses_rs2(id_uses_rs2_i), .match(wb_match)
    );

    assign raw_hazard = (FWD_EN != 0) ? (ex_match && ex_is_load_i)
                      : (ex_match || mem_match || (wb_match && (RF_BYPASS == 0)));

    assign wait_expired = (state_q == MEM_WAIT) && !mem_ack_i && (wait_q == WAIT_LAST);
    assign eff_state    = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        wait_d         = wait_q;
        timeout_d      = timeout_q;
        redirect_taken = 1'b0;
        pc_en_o        = 1'b1;
        id_en_o        = 1'b1;
        ex_en_o        = 1'b1;
        mem_en_o       = 1'b1;
        wb_en_o        = 1'b1;
        id_flush_o     = 1'b0;
        ex_flush_o     = 1'b0;
        mem_flush_o    = 1'b0;

        if ((state_q == MEM_WAIT) && !mem_ack_i && !wait_expired) begin
            {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = '0;
            wait_d = wait_q + 1'b1;
        end else if ((state_q != MEM_WAIT) && mem_req_i && !mem_ack_i) begin
            // The entry cycle is already frozen, so it counts as the first wait cycle.
            {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = '0;
            state_d = MEM_WAIT;
            ret_d   = state_q;
            wait_d  = WAIT_W'(1);
        end else begin
            // Release cycle of a wait is decoded as the state it interrupted.
            wait_d  = '0;
            state_d = RUN;
            if (wait_expired) begin
                timeout_d   = 1'b1;
                mem_flush_o = 1'b1;
            end
            if (!ex_mc_done_i && ((eff_state == MC_BUSY) || ex_mc_start_i)) begin
                pc_en_o     = 1'b0;
                id_en_o     = 1'b0;
                ex_en_o     = 1'b0;
                mem_flush_o = 1'b1;
                state_d     = MC_BUSY;
            end else if (ex_redirect_i) begin
                id_flush_o     = 1'b1;
                ex_flush_o     = 1'b1;
                redirect_taken = 1'b1;
            end else if (raw_hazard) begin
                pc_en_o    = 1'b0;
                id_en_o    = 1'b0;
                ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            if (!pc_en_o && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (redirect_taken && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign state_o       = state_q;
    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_q;
    assign flush_cnt_o   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl: three parameterisations checked
// every cycle against a rule-level model, plus directed scenario pins.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic use1, use2, ex_we, mem_we, wb_we, ex_load;
    logic redirect, mc_start, mc_done, mem_req, mem_ack;
    logic [2:0] pc_en, id_en, ex_en, mem_en, wb_en, id_fl, ex_fl, mem_fl, tmo;
    logic [1:0] st0, st1, st2;
    logic [15:0] sc0, fc0;
    logic [3:0] sc1, fc1, sc2, fc2;

    int total = 0;
    int bad   = 0;

    // Instance 0: stall-on-RAW, no bypass. 1: regfile bypass, minimum timeout. 2: forwarding.
    int P_FWD [3] = '{0, 0, 1};
    int P_BYP [3] = '{0, 1, 0};
    int P_TO  [3] = '{64, 2, 8};
    int P_MAX [3] = '{65535, 15, 15};

    int m_st [3], m_ret [3], m_wc [3], m_to [3], m_sc [3], m_fc [3];
    int n_st [3], n_ret [3], n_wc [3], n_to [3], n_sc [3], n_fc [3];
    logic [7:0] m_ctl [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(0), .MEM_TIMEOUT(64), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
        .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_we), .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_we),
        .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_we), .ex_is_load_i(ex_load), .ex_redirect_i(redirect),
        .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en[0]), .id_en_o(id_en[0]), .ex_en_o(ex_en[0]), .mem_en_o(mem_en[0]), .wb_en_o(wb_en[0]),
        .id_flush_o(id_fl[0]), .ex_flush_o(ex_fl[0]), .mem_flush_o(mem_fl[0]),
        .state_o(st0), .mem_timeout_o(tmo[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    pipe_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(1), .MEM_TIMEOUT(2), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
        .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_we), .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_we),
        .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_we), .ex_is_load_i(ex_load), .ex_redirect_i(redirect),
        .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en[1]), .id_en_o(id_en[1]), .ex_en_o(ex_en[1]), .mem_en_o(mem_en[1]), .wb_en_o(wb_en[1]),
        .id_flush_o(id_fl[1]), .ex_flush_o(ex_fl[1]), .mem_flush_o(mem_fl[1]),
        .state_o(st1), .mem_timeout_o(tmo[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    pipe_hazard_ctrl #(.FWD_EN(1), .RF_BYPASS(0), .MEM_TIMEOUT(8), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
        .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_we), .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_we),
        .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_we), .ex_is_load_i(ex_load), .ex_redirect_i(redirect),
        .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en[2]), .id_en_o(id_en[2]), .ex_en_o(ex_en[2]), .mem_en_o(mem_en[2]), .wb_en_o(wb_en[2]),
        .id_flush_o(id_fl[2]), .ex_flush_o(ex_fl[2]), .mem_flush_o(mem_fl[2]),
        .state_o(st2), .mem_timeout_o(tmo[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    function automatic logic [7:0] dut_ctl(int k);
        return {pc_en[k], id_en[k], ex_en[k], mem_en[k], wb_en[k], id_fl[k], ex_fl[k], mem_fl[k]};
    endfunction

    function automatic int dut_st(int k);
        return (k == 0) ? int'(st0) : (k == 1) ? int'(st1) : int'(st2);
    endfunction

    function automatic int dut_sc(int k);
        return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
    endfunction

    function automatic int dut_fc(int k);
        return (k == 0) ? int'(fc0) : (k == 1) ? int'(fc1) : int'(fc2);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the ID instruction depend on a producer this configuration cannot forward from?
    function automatic bit raw_seen(int k);
        logic [4:0] rd [3];
        bit we [3];
        bit hit;
        bit m;
        rd[0] = ex_rd;  rd[1] = mem_rd;  rd[2] = wb_rd;
        we[0] = ex_we;  we[1] = mem_we;  we[2] = wb_we;
        hit = 1'b0;
        for (int p = 0; p < 3; p++) begin
            m = we[p] && (rd[p] != 5'd0) &&
                (((rd[p] == id_rs1) && use1) || ((rd[p] == id_rs2) && use2));
            if (P_FWD[k] != 0) begin
                if ((p == 0) && ex_load && m) hit = 1'b1;
            end else if (!((p == 2) && (P_BYP[k] != 0)) && m) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // m_wc counts frozen cycles of the current memory wait (0 outside a wait).
    // Control vector bit order: {pc,id,ex,mem,wb en, id,ex,mem flush}.
    task automatic model_eval(int k);
        bit waiting;
        int home;
        waiting = (m_st[k] == 2);
        home    = waiting ? m_ret[k] : m_st[k];
        n_to[k] = m_to[k];
        n_fc[k] = m_fc[k];
        n_ret[k] = m_ret[k];
        if ((waiting && !mem_ack && (m_wc[k] < P_TO[k] - 1)) || (!waiting && mem_req && !mem_ack)) begin
            m_ctl[k] = 8'b00000_000;
            n_st[k]  = 2;
            n_ret[k] = home;
            n_wc[k]  = m_wc[k] + 1;
        end else begin
            m_ctl[k] = 8'b11111_000;
            n_wc[k]  = 0;
            n_st[k]  = 0;
            if (waiting && !mem_ack) begin
                n_to[k]     = 1;
                m_ctl[k][0] = 1'b1;
            end
            if (!mc_done && ((home == 1) || mc_start)) begin
                m_ctl[k][7:5] = 3'b000;
                m_ctl[k][0]   = 1'b1;
                n_st[k]       = 1;
            end else if (redirect) begin
                m_ctl[k][2:1] = 2'b11;
                n_fc[k] = (m_fc[k] == P_MAX[k]) ? m_fc[k] : m_fc[k] + 1;
            end else if (raw_seen(k)) begin
                m_ctl[k][7:6] = 2'b00;
                m_ctl[k][1]   = 1'b1;
            end
        end
        n_sc[k] = (!m_ctl[k][7] && (m_sc[k] != P_MAX[k])) ? m_sc[k] + 1 : m_sc[k];
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_ret[k] = 0; m_wc[k] = 0; m_to[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        use1 = 0; use2 = 0; ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0;
        redirect = 0; mc_start = 0; mc_done = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare all instances against the model, then advance one clock.
    task automatic step();
        for (int k = 0; k < 3; k++) begin
            model_eval(k);
            check($sformatf("ctl%0d", k), int'(dut_ctl(k)), int'(m_ctl[k]));
            check($sformatf("state%0d", k), dut_st(k), m_st[k]);
            check($sformatf("timeout%0d", k), int'(tmo[k]), m_to[k]);
            check($sformatf("stall_cnt%0d", k), dut_sc(k), m_sc[k]);
            check($sformatf("flush_cnt%0d", k), dut_fc(k), m_fc[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_st[k] = n_st[k]; m_ret[k] = n_ret[k]; m_wc[k] = n_wc[k];
            m_to[k] = n_to[k]; m_sc[k] = n_sc[k];   m_fc[k] = n_fc[k];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        model_clear();
        @(negedge clk);
        do_reset();

        settle();
        for (int k = 0; k < 3; k++) begin
            check("reset_ctl", int'(dut_ctl(k)), 8'hF8);
            check("reset_state", dut_st(k), 0);
            check("reset_stall_cnt", dut_sc(k), 0);
            check("reset_timeout", int'(tmo[k]), 0);
        end
        step();

        // add x5 in EX, ID reads x5: dependency walks EX -> MEM -> WB.
        do_reset();
        ex_rd = 5'd5; ex_we = 1; id_rs1 = 5'd5; use1 = 1; id_rs2 = 5'd1; use2 = 1;
        settle();
        check("raw_ex_nofwd", int'(dut_ctl(0)), 8'b00111_010);
        check("raw_ex_fwd_alu", int'(pc_en[2]), 1);
        step();
        ex_we = 0; mem_rd = 5'd5; mem_we = 1;
        settle();
        check("raw_mem_bypass", int'(pc_en[1]), 0);
        step();
        mem_we = 0; wb_rd = 5'd5; wb_we = 1;
        settle();
        check("raw_wb_nobypass", int'(pc_en[0]), 0);
        check("raw_wb_bypass", int'(pc_en[1]), 1);
        step();
        idle();
        settle();
        check("raw_stall_cnt0", dut_sc(0), 3);
        check("raw_stall_cnt1", dut_sc(1), 2);
        check("raw_stall_cnt2", dut_sc(2), 0);
        step();

        // Load-use with forwarding, then ALU producer with forwarding.
        do_reset();
        ex_rd = 5'd5; ex_we = 1; ex_load = 1; id_rs2 = 5'd5; use2 = 1;
        settle();
        check("loaduse_ctl", int'(dut_ctl(2)), 8'b00111_010);
        step();
        ex_load = 0;
        settle();
        check("alu_fwd_ctl", int'(dut_ctl(2)), 8'hF8);
        step();

        // Redirect overrides a concurrent RAW.
        do_reset();
        ex_rd = 5'd5; ex_we = 1; id_rs1 = 5'd5; use1 = 1; redirect = 1;
        settle();
        for (int k = 0; k < 3; k++) check("redirect_ctl", int'(dut_ctl(k)), 8'b11111_110);
        step();
        idle();
        settle();
        for (int k = 0; k < 3; k++) begin
            check("redirect_flush_cnt", dut_fc(k), 1);
            check("redirect_no_stall", dut_sc(k), 0);
        end
        step();

        // Multi-cycle op: 8 busy cycles, done on the 9th.
        do_reset();
        mc_start = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("mc_busy_ctl", int'(dut_ctl(0)), 8'b00011_001);
            step();
        end
        mc_done = 1;
        settle();
        check("mc_done_ctl", int'(dut_ctl(0)), 8'hF8);
        check("mc_done_state", dut_st(0), 1);
        step();
        idle();
        settle();
        check("mc_back_run", dut_st(0), 0);
        check("mc_stall_cnt", dut_sc(0), 8);
        step();

        // Memory never acks: 63 frozen cycles, then forced release.
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 63; i++) begin
            settle();
            check("mem_freeze_ctl", int'(dut_ctl(0)), 8'h00);
            step();
        end
        settle();
        check("mem_release_ctl", int'(dut_ctl(0)), 8'b11111_001);
        step();
        idle();
        settle();
        check("mem_timeout_sticky", int'(tmo[0]), 1);
        check("mem_timeout_stall_cnt", dut_sc(0), 63);
        check("mem_timeout_state", dut_st(0), 0);
        check("stall_cnt_saturate1", dut_sc(1), 15);
        check("stall_cnt_saturate2", dut_sc(2), 15);
        step();

        // Asynchronous reset in the middle of a multi-cycle op.
        do_reset();
        mc_start = 1;
        repeat (3) begin
            settle();
            step();
        end
        settle();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("async_rst_state", dut_st(k), 0);
            check("async_rst_stall_cnt", dut_sc(k), 0);
        end
        idle();
        model_clear();
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic over a small register window to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            id_rs1   = 5'($urandom_range(0, 3));
            id_rs2   = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            mem_rd   = 5'($urandom_range(0, 3));
            wb_rd    = 5'($urandom_range(0, 3));
            use1     = 1'($urandom_range(0, 1));
            use2     = 1'($urandom_range(0, 1));
            ex_we    = 1'($urandom_range(0, 1));
            mem_we   = 1'($urandom_range(0, 1));
            wb_we    = 1'($urandom_range(0, 1));
            ex_load  = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 7) == 0);
            mc_start = ($urandom_range(0, 9) == 0);
            mc_done  = ($urandom_range(0, 3) == 0);
            mem_req  = ($urandom_range(0, 9) == 0);
            mem_ack  = ($urandom_range(0, 2) == 0);
            settle();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
